vga_timing_ctrl: RTL and testbench

VGA_TIMING_CTRL -- requirements
Module: vga_timing_ctrl

---
 rtl/vga_pkg.sv | 37 +++
 rtl/vga_axis_counter.sv | 63 ++++++
 rtl/vga_timing_ctrl.sv | 104 ++++++++++
 tb/tb_vga_timing_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing types and default 640x480@60 timing constants.
package vga_pkg;

    // Phase of one display axis, in scan order.
    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FRONT  = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BACK   = 2'd3
    } phase_e;

    // Output count width; both default totals (800, 525) fit.
    localparam int unsigned CNT_W = 10;
    // Pixel divider width; covers PIX_DIV up to 16.
    localparam int unsigned DIV_W = 4;

    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;

    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;

    // Phase that follows p once p's last count has been reached.
    function automatic phase_e next_phase(input phase_e p);
        case (p)
            PH_ACTIVE: next_phase = PH_FRONT;
            PH_FRONT:  next_phase = PH_SYNC;
            PH_SYNC:   next_phase = PH_BACK;
            default:   next_phase = PH_ACTIVE;
        endcase
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One display axis: position counter with wrap and a phase FSM kept in lockstep.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int unsigned ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned FP     = VGA_H_FP,
    parameter int unsigned SYNC   = VGA_H_SYNC,
    parameter int unsigned BP     = VGA_H_BP,
    parameter int unsigned W      = CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         adv,
    output logic [W-1:0] count,
    output phase_e       phase
);

    localparam int unsigned TOTAL = ACTIVE + FP + SYNC + BP;

    // Last count of each phase; the phase changes on the advance that leaves it.
    localparam logic [W-1:0] LAST_ACTIVE = W'(ACTIVE - 1);
    localparam logic [W-1:0] LAST_FRONT  = W'(ACTIVE + FP - 1);
    localparam logic [W-1:0] LAST_SYNC   = W'(ACTIVE + FP + SYNC - 1);
    localparam logic [W-1:0] LAST_TOTAL  = W'(TOTAL - 1);

    logic [W-1:0] count_q, count_d;
    phase_e       phase_q, phase_d;
    logic         at_phase_end;

    // Next count and phase; both move on the same advance so they never disagree.
    always_comb begin
        count_d      = count_q;
        phase_d      = phase_q;
        at_phase_end = 1'b0;
        case (phase_q)
            PH_ACTIVE: at_phase_end = (count_q == LAST_ACTIVE);
            PH_FRONT:  at_phase_end = (count_q == LAST_FRONT);
            PH_SYNC:   at_phase_end = (count_q == LAST_SYNC);
            default:   at_phase_end = (count_q == LAST_TOTAL);
        endcase
        if (adv) begin
            count_d = (count_q == LAST_TOTAL) ? '0 : count_q + W'(1);
            if (at_phase_end) begin
                phase_d = next_phase(phase_q);
            end
        end
    end

    // Axis state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            phase_q <= PH_ACTIVE;
        end else begin
            count_q <= count_d;
            phase_q <= phase_d;
        end
    end

    assign count = count_q;
    assign phase = phase_q;

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA timing generator: pixel strobe divider plus horizontal and vertical axis counters.
module vga_timing_ctrl
    import vga_pkg::*;
#(
    parameter int unsigned PIX_DIV  = 2,
    parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned H_FP     = VGA_H_FP,
    parameter int unsigned H_SYNC   = VGA_H_SYNC,
    parameter int unsigned H_BP     = VGA_H_BP,
    parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
    parameter int unsigned V_FP     = VGA_V_FP,
    parameter int unsigned V_SYNC   = VGA_V_SYNC,
    parameter int unsigned V_BP     = VGA_V_BP,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic             pix_ce,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic             line_end,
    output logic             frame_start
);

    localparam int unsigned    H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

    logic             running_q, running_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             pix_ce_c;
    logic             line_end_c;
    logic [CNT_W-1:0] h_count, v_count;
    phase_e           h_phase, v_phase;

    // Run flag and pixel divider; the divider freezes wherever it is while stopped.
    always_comb begin
        running_d = en;
        div_d     = div_q;
        if (running_q) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        end
    end

    // Run and divider registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            running_q <= 1'b0;
            div_q     <= '0;
        end else begin
            running_q <= running_d;
            div_q     <= div_d;
        end
    end

    assign pix_ce_c   = running_q && (div_q == '0);
    assign line_end_c = pix_ce_c && (h_count == H_LAST);

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .W      (CNT_W)
    ) u_h_axis (
        .clk    (clk),
        .reset  (reset),
        .adv    (pix_ce_c),
        .count  (h_count),
        .phase  (h_phase)
    );

    // Vertical axis steps once per completed line.
    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .W      (CNT_W)
    ) u_v_axis (
        .clk    (clk),
        .reset  (reset),
        .adv    (line_end_c),
        .count  (v_count),
        .phase  (v_phase)
    );

    // Output decode from registered state; everything but x/y is gated by running.
    always_comb begin
        pix_ce      = pix_ce_c;
        x           = h_count;
        y           = v_count;
        hsync       = (running_q && (h_phase == PH_SYNC)) ? SYNC_POL : ~SYNC_POL;
        vsync       = (running_q && (v_phase == PH_SYNC)) ? SYNC_POL : ~SYNC_POL;
        video_on    = running_q && (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
        line_end    = line_end_c;
        frame_start = pix_ce_c && (h_count == '0) && (v_count == '0);
    end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Scoreboard bench: a linear pixel-position model predicts every cycle of two DUT configurations.
module tb_vga_timing_ctrl;

    localparam int HA = 640, HF = 16, HS = 96, HB = 48, HT = HA + HF + HS + HB;
    localparam int VA = 6, VF = 2, VS = 2, VB = 3, VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic en = 1'b0;
    always #5 clk = ~clk;

    logic       a_ce, a_hs, a_vs, a_vid, a_le, a_fs;
    logic [9:0] a_x, a_y;
    logic       b_ce, b_hs, b_vs, b_vid, b_le, b_fs;
    logic [9:0] b_x, b_y;

    vga_timing_ctrl #(
        .PIX_DIV(2), .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b0)
    ) u_dut_a (
        .clk(clk), .reset(reset), .en(en), .pix_ce(a_ce), .x(a_x), .y(a_y),
        .hsync(a_hs), .vsync(a_vs), .video_on(a_vid), .line_end(a_le), .frame_start(a_fs)
    );

    vga_timing_ctrl #(
        .PIX_DIV(1), .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b1)
    ) u_dut_b (
        .clk(clk), .reset(reset), .en(en), .pix_ce(b_ce), .x(b_x), .y(b_y),
        .hsync(b_hs), .vsync(b_vs), .video_on(b_vid), .line_end(b_le), .frame_start(b_fs)
    );

    typedef struct {
        logic       ce;
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       vid;
        logic       le;
        logic       fs;
    } rec_t;

    int p_div [2] = '{2, 1};
    bit p_pol [2] = '{1'b0, 1'b1};

    // Model state: run flag, divider phase, linear pixel index within the frame.
    bit m_run [2];
    int m_div [2];
    int m_pos [2];

    rec_t q0[$];
    rec_t q1[$];

    int checks = 0;
    int errors = 0;
    int cycle = 0;

    // Per-frame tallies of pix_ce events, measured on the DUT.
    int  t_ce [2];
    int  t_hs [2];
    int  t_vs [2];
    int  t_vid [2];
    bit  t_ok [2];

    function automatic rec_t model_out(input int i);
        rec_t r;
        int   px, py;
        bit   ce;
        px = m_pos[i] % HT;
        py = m_pos[i] / HT;
        ce = m_run[i] && (m_div[i] == 0);
        r.ce  = ce;
        r.x   = 10'(px);
        r.y   = 10'(py);
        r.hs  = (m_run[i] && px >= HA + HF && px < HA + HF + HS) ? p_pol[i] : !p_pol[i];
        r.vs  = (m_run[i] && py >= VA + VF && py < VA + VF + VS) ? p_pol[i] : !p_pol[i];
        r.vid = m_run[i] && px < HA && py < VA;
        r.le  = ce && px == HT - 1;
        r.fs  = ce && m_pos[i] == 0;
        return r;
    endfunction

    task automatic model_clock(input int i, input bit e, input bit r);
        if (r) begin
            m_run[i] = 1'b0;
            m_div[i] = 0;
            m_pos[i] = 0;
        end else begin
            if (m_run[i]) begin
                if (m_div[i] == 0) m_pos[i] = (m_pos[i] + 1) % FRAME;
                m_div[i] = (m_div[i] + 1) % p_div[i];
            end
            m_run[i] = e;
        end
    endtask

    // Drive one clock of stimulus and queue what both DUTs must show this cycle.
    task automatic step(input bit e, input bit r);
        en    = e;
        reset = r;
        q0.push_back(model_out(0));
        q1.push_back(model_out(1));
        model_clock(0, e, r);
        model_clock(1, e, r);
        @(posedge clk);
        #1;
    endtask

    // Run until instance A's model presents pixel index pos on a strobe.
    task automatic run_to(input int pos);
        int n;
        n = 0;
        while (!(m_pos[0] == pos && m_div[0] == 0 && m_run[0]) && n < 2 * FRAME + 10) begin
            step(1'b1, 1'b0);
            n++;
        end
    endtask

    function automatic rec_t dut_rec(input int i);
        rec_t r;
        if (i == 0) begin
            r.ce = a_ce; r.x = a_x; r.y = a_y; r.hs = a_hs; r.vs = a_vs;
            r.vid = a_vid; r.le = a_le; r.fs = a_fs;
        end else begin
            r.ce = b_ce; r.x = b_x; r.y = b_y; r.hs = b_hs; r.vs = b_vs;
            r.vid = b_vid; r.le = b_le; r.fs = b_fs;
        end
        return r;
    endfunction

    task automatic compare(input int i, input rec_t e, input rec_t a);
        checks++;
        if (a.ce !== e.ce || a.x !== e.x || a.y !== e.y || a.hs !== e.hs || a.vs !== e.vs ||
            a.vid !== e.vid || a.le !== e.le || a.fs !== e.fs) begin
            errors++;
            $display("FAIL cycle_rec inst%0d cyc%0d got ce=%b x=%0d y=%0d hs=%b vs=%b vid=%b le=%b fs=%b exp ce=%b x=%0d y=%0d hs=%b vs=%b vid=%b le=%b fs=%b",
                     i, cycle, a.ce, a.x, a.y, a.hs, a.vs, a.vid, a.le, a.fs,
                     e.ce, e.x, e.y, e.hs, e.vs, e.vid, e.le, e.fs);
        end
    endtask

    task automatic check_eq(input int i, input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s inst%0d got %0d exp %0d", name, i, got, exp);
        end
    endtask

    // Whole-frame event counts, checked between consecutive undisturbed frame_starts.
    task automatic tally(input int i, input rec_t a);
        if (a.ce === 1'b1) begin
            if (a.fs === 1'b1) begin
                if (t_ok[i]) begin
                    check_eq(i, "frame_pix_ce", t_ce[i], FRAME);
                    check_eq(i, "frame_hsync", t_hs[i], HS * VT);
                    check_eq(i, "frame_vsync", t_vs[i], VS * HT);
                    check_eq(i, "frame_video", t_vid[i], HA * VA);
                end
                t_ce[i] = 0; t_hs[i] = 0; t_vs[i] = 0; t_vid[i] = 0;
                t_ok[i] = 1'b1;
            end
            t_ce[i]++;
            if (a.hs === p_pol[i]) t_hs[i]++;
            if (a.vs === p_pol[i]) t_vs[i]++;
            if (a.vid === 1'b1) t_vid[i]++;
        end
        if (reset) t_ok[i] = 1'b0;
    endtask

    // Monitor: pop and compare the expected record for every presented cycle.
    initial begin
        rec_t e;
        rec_t a;
        forever begin
            @(negedge clk);
            cycle++;
            if (q0.size() > 0) begin
                e = q0.pop_front();
                a = dut_rec(0);
                compare(0, e, a);
                tally(0, a);
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                a = dut_rec(1);
                compare(1, e, a);
                tally(1, a);
            end
        end
    end

    // Stimulus.
    initial begin
        for (int i = 0; i < 2; i++) begin
            m_run[i] = 1'b0; m_div[i] = 0; m_pos[i] = 0;
            t_ok[i] = 1'b0; t_ce[i] = 0; t_hs[i] = 0; t_vs[i] = 0; t_vid[i] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        repeat (FRAME * 2 + 200) step(1'b1, 1'b0);
        run_to(3 * HT + 300);
        repeat (50) step(1'b0, 1'b0);
        repeat (2000) step(1'b1, 1'b0);
        run_to((VA + VF + 1) * HT + 700);
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        repeat (5) step(1'b0, 1'b0);
        repeat (FRAME * 2 + 100) step(1'b1, 1'b0);
        for (int k = 0; k < 30000; k++) begin
            step($urandom_range(0, 15) != 0, $urandom_range(0, 3999) == 0);
        end
        step(1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check_eq(0, "queue_drained", q0.size() + q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #5ms;
        $display("FAIL watchdog time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

endmodule
